load_store_aligner: RTL and testbench
=====================================

// Module: load_store_aligner
// PURPOSE
// - Parametrised load/store data path between the execute stage and the data memory port.
// - Adds byte-offset alignment, byte strobes and splitting of boundary-crossing accesses.
// - Converts a funct3-tagged request into one or two word-aligned bus beats.
// - For loads, merges and shifts the returned data, then sign- or zero-extends it.
// - Returns the result through a valid/ready response port.
// PARAMETERS
// - XLEN            32  data width, 32 or 64; BYTES = XLEN/8, OFFW = log2(BYTES)
// - MISALIGN_SPLIT  1   1: split boundary-crossing accesses into 2 beats; 0: flag them as errors
// PORTS
// - clk           in   1      clock; all state changes on the rising edge
// - rst           in   1      synchronous, active-high reset
// - req_valid     in   1      request valid
// - req_ready     out  1      high only in IDLE and when rst=0; accept = req_valid & req_ready
// - req_load      in   1      load request (if both req_load and req_store are 0: error response)
// - req_store     in   1      store request (req_load has priority if both are 1)
// - req_funct3    in   3      RISC-V funct3 (access size and signedness)
// - req_addr      in   32     byte address
// - req_wdata     in   XLEN   store data, LSB-justified
// - mem_valid     out  1      bus beat valid; held with stable fields until mem_ready
// - mem_ready     in   1      bus beat accepted
// - mem_we        out  1      1 = write beat
// - mem_addr      out  32     word-aligned beat address (low OFFW bits are 0)
// - mem_wstrb     out  BYTES  byte write strobes; 0 on read beats
// - mem_wdata     out  XLEN   write data, shifted to byte lanes
// - mem_rvalid    in   1      read data valid, at least 1 cycle after the read beat is accepted
// - mem_rdata     in   XLEN   read data for the outstanding read beat
// - rsp_valid     out  1      response valid; held until rsp_ready
// - rsp_ready     in   1      response consumed
// - rsp_data      out  XLEN   extended load result; 0 for stores and errors
// - rsp_err       out  1      illegal funct3, or a crossing access when MISALIGN_SPLIT=0
// BEHAVIOUR
// - Reset: state returns to IDLE; mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr,
//   rsp_valid, rsp_data and rsp_err are all 0; req_ready is 0 while rst=1.
// - Sizes:
//   - size_bytes = 1 << funct3[1:0]; off = req_addr[OFFW-1:0].
//   - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU only when XLEN=64.
//   - Store funct3: 000, 001, 010; 011 only when XLEN=64.
//   - Any other funct3 is illegal.
// - crossing = (off + size_bytes > BYTES). Beat0 address = {req_addr[31:OFFW], 0}.
//   Beat1 address = beat0 address + BYTES; the 32-bit addition wraps.
// - Strobes and write data:
//   - 2*BYTES mask = ((1 << size_bytes) - 1) << off; beat0 uses the low half, beat1 the high half.
//   - 2*XLEN word  = wdata << (8*off); beat0 uses the low half, beat1 the high half.
//   - Bytes outside the mask are driven 0.
// - FSM: IDLE -> ISSUE0 -> [WAIT0] -> [ISSUE1 -> [WAIT1]] -> RESP -> IDLE.
//   - IDLE: on accept, latch the request.
//     - Illegal request, or crossing with MISALIGN_SPLIT=0: go straight to RESP with err=1 and no bus beat.
//     - Otherwise go to ISSUE0.
//   - ISSUE0/ISSUE1: mem_valid=1.
//     - On mem_ready, a store goes to the next beat or RESP; a load goes to WAIT0/WAIT1.
//   - WAIT0/WAIT1: capture mem_rdata on mem_rvalid, then go to ISSUE1 (crossing) or RESP.
//   - RESP: rsp_valid=1; on rsp_ready, go to IDLE.
//   - Back-to-back request: the next request can be accepted in the cycle after rsp_valid&rsp_ready.
// - Latency: mem_valid rises 1 cycle after accept. rsp_valid rises 1 cycle after the final
//   mem_rvalid (load) or the final mem_valid&mem_ready (store). An error response is 1 cycle after accept.
// - Load merge: {rdata1, rdata0} >> (8*off); rdata1 = 0 for a single beat. The low size_bytes bytes
//   are sign-extended (LB, LH, LW on XLEN=64) or zero-extended (LBU, LHU, LWU); LW/LD on native width pass through.
// - mem_rvalid outside WAIT0/WAIT1 is ignored. mem_ready while mem_valid=0 is ignored.
// - Reset mid-operation: the access is abandoned and no response is produced. mem_valid is 0 in
//   the cycle after rst is sampled. A late mem_rvalid arriving after reset is ignored.
// TESTING
// - LB addr 0x1003, rdata 0x80FF_1234 -> mem_addr 0x1000, 1 beat, rsp_data 0xFFFF_FF80, err 0.
// - LHU addr 0x1002, rdata 0xBEEF_0000 -> rsp_data 0x0000_BEEF, err 0.
// - SH addr 0x2001, wdata 0x0000_ABCD -> 1 beat, mem_wstrb 4'b0110, mem_wdata 0x00AB_CD00, rsp_data 0.
// - LW addr 0x3002, split=1, rdata 0x5566_7788 @0x3000 then 0x1122_3344 @0x3004
//   -> 2 beats, rsp_data 0x3344_5566.
//   The same request with split=0 -> no mem_valid, rsp_err=1 one cycle after accept.
// - SW addr 0x4003, wdata 0xAABB_CCDD, split=1
//   -> beat0 @0x4000 wstrb 4'b1000, wdata 0xDD00_0000.
//   -> beat1 @0x4004 wstrb 4'b0111, wdata 0x00AA_BBCC.
//   Hold mem_ready low 3 cycles on beat0 -> fields stay stable.
// - rst asserted in WAIT1 -> next cycle mem_valid=0, rsp_valid=0; after rst drops, req_ready=1.
//   A stray mem_rvalid in IDLE produces no response.

Source files
------------

// File: rtl/load_store_aligner_if.sv
// load_store_aligner_if
// Bundles the three handshake channels of the load/store aligner:
//   request  : req_valid/req_ready, req_load, req_store, req_funct3, req_addr, req_wdata
//   memory   : mem_valid/mem_ready, mem_we, mem_addr, mem_wstrb, mem_wdata,
//              mem_rvalid, mem_rdata
//   response : rsp_valid/rsp_ready, rsp_data, rsp_err
// Modports:
//   slave  - the aligner's view (consumes requests, drives bus beats and responses)
//   master - the environment's view (execute stage plus data memory)
interface load_store_aligner_if #(
  parameter int XLEN = 32
);
  localparam int BYTES = XLEN / 8;

  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [XLEN-1:0]  req_wdata;

  logic             mem_valid;
  logic             mem_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [BYTES-1:0] mem_wstrb;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/load_store_aligner.sv
// load_store_aligner
// Load/store data path between the execute stage and a word-wide data memory port.
// A funct3-tagged request becomes one or two word-aligned bus beats with byte strobes;
// load data is merged across beats, shifted down and sign/zero-extended.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; abandons any access in flight
//   bus  - load_store_aligner_if.slave (request, memory and response channels)
// Parameters:
//   XLEN           - 32 or 64
//   MISALIGN_SPLIT - 1: split word-crossing accesses into two beats; 0: reject them
module load_store_aligner #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_aligner_if.slave  bus
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int MW    = 2 * BYTES;
  localparam int DW    = 2 * XLEN;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } state_t;

  state_t state, state_next;

  logic            load_q;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;
  logic [31:0]     base_q;
  logic [XLEN-1:0] wdata_q;
  logic            cross_q;
  logic            err_q;
  logic [XLEN-1:0] rdata0_q;
  logic [XLEN-1:0] rdata1_q;

  logic            req_ready_int;
  logic            accept;
  logic [OFFW-1:0] req_off;
  logic [7:0]      req_size;
  logic            req_cross;
  logic            req_legal;
  logic            req_reject;

  logic [7:0]      size_q;
  logic [MW-1:0]   mask_w;
  logic [DW-1:0]   wide_w;
  logic [DW-1:0]   wide_m;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] ext_data;
  logic            sign_bit;

  function automatic logic is_legal(input logic ld, input logic st, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (ld) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        3'b011, 3'b110:                         ok = (XLEN == 64);
        default:                                ok = 1'b0;
      endcase
    end else if (st) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        3'b011:                 ok = (XLEN == 64);
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  assign req_ready_int = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && req_ready_int;

  // Request decode, used only in the accept cycle.
  always_comb begin
    req_off    = bus.req_addr[OFFW-1:0];
    req_size   = 8'd1 << bus.req_funct3[1:0];
    req_cross  = (8'(req_off) + req_size) > 8'(BYTES);
    req_legal  = is_legal(bus.req_load, bus.req_store, bus.req_funct3);
    req_reject = !req_legal || (req_cross && !MISALIGN_SPLIT);
  end

  // Store lanes: the byte mask and the shifted data span two words; each beat
  // takes one half. Bytes outside the mask are forced to zero.
  always_comb begin
    size_q = 8'd1 << f3_q[1:0];
    mask_w = ((MW'(1) << size_q) - MW'(1)) << off_q;
    wide_w = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    wide_m = '0;
    for (int i = 0; i < MW; i++) begin
      wide_m[8*i +: 8] = mask_w[i] ? wide_w[8*i +: 8] : 8'h00;
    end
  end

  // Load merge and extension. rdata1_q is cleared on accept so a single-beat
  // load shifts in zeros from the upper word.
  always_comb begin
    merged = XLEN'({rdata1_q, rdata0_q} >> {off_q, 3'b000});
    case (f3_q[1:0])
      2'b00:   sign_bit = merged[7];
      2'b01:   sign_bit = merged[15];
      2'b10:   sign_bit = merged[31];
      default: sign_bit = merged[XLEN-1];
    endcase
    ext_data = '0;
    for (int b = 0; b < XLEN; b++) begin
      if (b < 8 * int'(size_q)) ext_data[b] = merged[b];
      else                      ext_data[b] = !f3_q[2] && sign_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and bus outputs. Bus fields are gated by mem_valid so they read
  // as zero whenever no beat is being offered, including during reset.
  always_comb begin
    state_next    = state;
    bus.req_ready = req_ready_int;
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstrb = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) state_next = req_reject ? RESP : ISSUE0;
      end
      ISSUE0: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = !load_q;
        bus.mem_addr  = base_q;
        bus.mem_wstrb = load_q ? '0 : mask_w[BYTES-1:0];
        bus.mem_wdata = load_q ? '0 : wide_m[XLEN-1:0];
        if (bus.mem_ready) begin
          if (load_q)       state_next = WAIT0;
          else if (cross_q) state_next = ISSUE1;
          else              state_next = RESP;
        end
      end
      WAIT0: begin
        if (bus.mem_rvalid) state_next = cross_q ? ISSUE1 : RESP;
      end
      ISSUE1: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = !load_q;
        bus.mem_addr  = base_q + 32'(BYTES);
        bus.mem_wstrb = load_q ? '0 : mask_w[MW-1:BYTES];
        bus.mem_wdata = load_q ? '0 : wide_m[DW-1:XLEN];
        if (bus.mem_ready) state_next = load_q ? WAIT1 : RESP;
      end
      WAIT1: begin
        if (bus.mem_rvalid) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_data  = (load_q && !err_q) ? ext_data : '0;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q   <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      cross_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        load_q   <= bus.req_load;
        f3_q     <= bus.req_funct3;
        off_q    <= req_off;
        base_q   <= {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
        wdata_q  <= bus.req_wdata;
        cross_q  <= req_cross;
        err_q    <= req_reject;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state == WAIT0 && bus.mem_rvalid) rdata0_q <= bus.mem_rdata;
      if (state == WAIT1 && bus.mem_rvalid) rdata1_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_aligner.sv
// tb_load_store_aligner
// Directed bench for load_store_aligner at XLEN=32. dut1 splits crossing
// accesses, dut0 rejects them. Inputs change on the falling edge and outputs
// are sampled there too, so each check sees the state after the last rising edge.
module tb_load_store_aligner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   error_count = 0;
  int   check_count = 0;

  always #5 clk = ~clk;

  load_store_aligner_if #(.XLEN(32)) bus1 ();
  load_store_aligner_if #(.XLEN(32)) bus0 ();

  load_store_aligner #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  load_store_aligner #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request to dut1 for a single cycle; it must be accepted.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    checkOutput("req_ready before request", bus1.req_ready, 1);
    bus1.req_valid  = 1'b1;
    bus1.req_load   = ld;
    bus1.req_store  = st;
    bus1.req_funct3 = f3;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
  endtask

  // Checks the offered beat, accepts it, and optionally returns read data.
  task automatic serveBeat(input string tag, input logic [31:0] addr, input logic we,
                           input logic [3:0] strb, input logic [31:0] wd,
                           input logic give_rdata, input logic [31:0] rd);
    checkOutput({tag, " mem_valid"}, bus1.mem_valid, 1);
    checkOutput({tag, " mem_addr"},  bus1.mem_addr, addr);
    checkOutput({tag, " mem_we"},    bus1.mem_we, we);
    checkOutput({tag, " mem_wstrb"}, bus1.mem_wstrb, strb);
    checkOutput({tag, " mem_wdata"}, bus1.mem_wdata, wd);
    bus1.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.mem_ready = 1'b0;
    if (give_rdata) begin
      checkOutput({tag, " no beat while waiting"}, bus1.mem_valid, 0);
      bus1.mem_rvalid = 1'b1;
      bus1.mem_rdata  = rd;
      @(posedge clk);
      @(negedge clk);
      bus1.mem_rvalid = 1'b0;
      bus1.mem_rdata  = '0;
    end
  endtask

  // Response must already be valid; consume it and confirm it drops.
  task automatic finishResp(input string tag, input logic [31:0] data, input logic err);
    checkOutput({tag, " rsp_valid"}, bus1.rsp_valid, 1);
    checkOutput({tag, " rsp_data"},  bus1.rsp_data, data);
    checkOutput({tag, " rsp_err"},   bus1.rsp_err, err);
    checkOutput({tag, " mem_valid in resp"}, bus1.mem_valid, 0);
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    checkOutput({tag, " rsp_valid dropped"}, bus1.rsp_valid, 0);
  endtask

  initial begin
    bus1.req_valid = 0; bus1.req_load = 0; bus1.req_store = 0; bus1.req_funct3 = 0;
    bus1.req_addr = 0; bus1.req_wdata = 0; bus1.mem_ready = 0; bus1.mem_rvalid = 0;
    bus1.mem_rdata = 0; bus1.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_load = 0; bus0.req_store = 0; bus0.req_funct3 = 0;
    bus0.req_addr = 0; bus0.req_wdata = 0; bus0.mem_ready = 0; bus0.mem_rvalid = 0;
    bus0.mem_rdata = 0; bus0.rsp_ready = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", bus1.req_ready, 0);
    checkOutput("reset mem_valid", bus1.mem_valid, 0);
    checkOutput("reset mem_we",    bus1.mem_we, 0);
    checkOutput("reset mem_addr",  bus1.mem_addr, 0);
    checkOutput("reset mem_wstrb", bus1.mem_wstrb, 0);
    checkOutput("reset mem_wdata", bus1.mem_wdata, 0);
    checkOutput("reset rsp_valid", bus1.rsp_valid, 0);
    checkOutput("reset rsp_data",  bus1.rsp_data, 0);
    checkOutput("reset rsp_err",   bus1.rsp_err, 0);
    rst = 1'b0;
    #1;

    // LB from the top byte: sign-extended 0x80.
    applyStimulus(1, 0, 3'b000, 32'h0000_1003, 32'h0);
    serveBeat("lb", 32'h0000_1000, 0, 4'b0000, 32'h0, 1, 32'h80FF_1234);
    finishResp("lb", 32'hFFFF_FF80, 0);

    // LHU upper half, accepted back-to-back after the previous response.
    applyStimulus(1, 0, 3'b101, 32'h0000_1002, 32'h0);
    serveBeat("lhu", 32'h0000_1000, 0, 4'b0000, 32'h0, 1, 32'hBEEF_0000);
    finishResp("lhu", 32'h0000_BEEF, 0);

    // LBU middle byte: zero-extended.
    applyStimulus(1, 0, 3'b100, 32'h0000_6001, 32'h0);
    serveBeat("lbu", 32'h0000_6000, 0, 4'b0000, 32'h0, 1, 32'h0000_F100);
    finishResp("lbu", 32'h0000_00F1, 0);

    // LH aligned: sign-extended.
    applyStimulus(1, 0, 3'b001, 32'h0000_7000, 32'h0);
    serveBeat("lh", 32'h0000_7000, 0, 4'b0000, 32'h0, 1, 32'hFFFF_8001);
    finishResp("lh", 32'hFFFF_8001, 0);

    // SH at offset 1.
    applyStimulus(0, 1, 3'b001, 32'h0000_2001, 32'h0000_ABCD);
    serveBeat("sh", 32'h0000_2000, 1, 4'b0110, 32'h00AB_CD00, 0, 32'h0);
    finishResp("sh", 32'h0, 0);

    // SB: bytes above the access size must not leak onto the bus.
    applyStimulus(0, 1, 3'b000, 32'h0000_8002, 32'h1234_56EF);
    serveBeat("sb", 32'h0000_8000, 1, 4'b0100, 32'h00EF_0000, 0, 32'h0);
    finishResp("sb", 32'h0, 0);

    // LW crossing a word boundary: two beats merged.
    applyStimulus(1, 0, 3'b010, 32'h0000_3002, 32'h0);
    serveBeat("lw split b0", 32'h0000_3000, 0, 4'b0000, 32'h0, 1, 32'h5566_7788);
    serveBeat("lw split b1", 32'h0000_3004, 0, 4'b0000, 32'h0, 1, 32'h1122_3344);
    finishResp("lw split", 32'h3344_5566, 0);

    // LH at the top of the address space: beat1 address wraps to 0.
    applyStimulus(1, 0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    serveBeat("lh wrap b0", 32'hFFFF_FFFC, 0, 4'b0000, 32'h0, 1, 32'hAB00_0000);
    serveBeat("lh wrap b1", 32'h0000_0000, 0, 4'b0000, 32'h0, 1, 32'h0000_00CD);
    finishResp("lh wrap", 32'hFFFF_CDAB, 0);

    // SW crossing, beat0 stalled for three cycles.
    applyStimulus(0, 1, 3'b010, 32'h0000_4003, 32'hAABB_CCDD);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw stall mem_valid", bus1.mem_valid, 1);
      checkOutput("sw stall mem_addr",  bus1.mem_addr, 32'h0000_4000);
      checkOutput("sw stall mem_wstrb", bus1.mem_wstrb, 4'b1000);
      checkOutput("sw stall mem_wdata", bus1.mem_wdata, 32'hDD00_0000);
      @(posedge clk);
      @(negedge clk);
    end
    serveBeat("sw b0", 32'h0000_4000, 1, 4'b1000, 32'hDD00_0000, 0, 32'h0);
    serveBeat("sw b1", 32'h0000_4004, 1, 4'b0111, 32'h00AA_BBCC, 0, 32'h0);
    finishResp("sw", 32'h0, 0);

    // Illegal funct3 for XLEN=32, and a request that is neither load nor store.
    applyStimulus(1, 0, 3'b011, 32'h0000_5000, 32'h0);
    finishResp("ld illegal", 32'h0, 1);
    applyStimulus(0, 0, 3'b010, 32'h0000_5000, 32'h0);
    finishResp("no op", 32'h0, 1);

    // Crossing LW on the non-splitting instance: error, no bus beat.
    checkOutput("nosplit req_ready", bus0.req_ready, 1);
    bus0.req_valid  = 1'b1;
    bus0.req_load   = 1'b1;
    bus0.req_funct3 = 3'b010;
    bus0.req_addr   = 32'h0000_3002;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    checkOutput("nosplit mem_valid", bus0.mem_valid, 0);
    checkOutput("nosplit rsp_valid", bus0.rsp_valid, 1);
    checkOutput("nosplit rsp_err",   bus0.rsp_err, 1);
    checkOutput("nosplit rsp_data",  bus0.rsp_data, 0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    checkOutput("nosplit rsp_valid dropped", bus0.rsp_valid, 0);

    // Reset while waiting for the second read beat.
    applyStimulus(1, 0, 3'b010, 32'h0000_3002, 32'h0);
    serveBeat("rst b0", 32'h0000_3000, 0, 4'b0000, 32'h0, 1, 32'h5566_7788);
    serveBeat("rst b1", 32'h0000_3004, 0, 4'b0000, 32'h0, 0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst mem_valid", bus1.mem_valid, 0);
    checkOutput("rst rsp_valid", bus1.rsp_valid, 0);
    checkOutput("rst req_ready", bus1.req_ready, 0);
    rst = 1'b0;
    bus1.mem_rvalid = 1'b1;
    bus1.mem_rdata  = 32'h1122_3344;
    #1;
    checkOutput("post rst req_ready", bus1.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus1.mem_rvalid = 1'b0;
    checkOutput("late rvalid rsp_valid", bus1.rsp_valid, 0);
    checkOutput("late rvalid mem_valid", bus1.mem_valid, 0);
    bus1.mem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.mem_rvalid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stray rvalid rsp_valid", bus1.rsp_valid, 0);
    end

    // Recovery: an aligned LW passes through unchanged.
    applyStimulus(1, 0, 3'b010, 32'h0000_5000, 32'h0);
    serveBeat("lw", 32'h0000_5000, 0, 4'b0000, 32'h0, 1, 32'h8000_0001);
    finishResp("lw", 32'h8000_0001, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
